// File: rtl/vga_palette_dac.sv
// VGA attribute palette + 256x18 DAC RAM pixel pipeline, with the host-side
// 3C7/3C8/3C9 index and R/G/B triplet register interface.
module vga_palette_dac (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_pal_dac,
  input  logic       horiz_sync_pal_dac_i,
  input  logic       vert_sync_pal_dac_i,
  input  logic       video_on_h_pal_dac_i,
  input  logic       video_on_v_pal_dac_i,
  input  logic [7:0] character_pal_dac_i,
  input  logic       graphics_alpha,
  input  logic       shift_reg1,
  input  logic [3:0] pal_addr,
  input  logic       pal_we,
  input  logic [5:0] pal_write,
  output logic [5:0] pal_read,
  input  logic       dac_wr_idx_we,
  input  logic       dac_rd_idx_we,
  input  logic [7:0] dac_idx_i,
  input  logic       dac_dat_we,
  input  logic       dac_dat_re,
  input  logic [5:0] dac_dat_i,
  output logic [5:0] dac_dat_o,
  output logic [1:0] dac_state_o,
  output logic [3:0] vga_red_o,
  output logic [3:0] vga_green_o,
  output logic [3:0] vga_blue_o,
  output logic       horiz_sync_o,
  output logic       vert_sync_o
);

  typedef enum logic [1:0] {CompR, CompG, CompB} comp_e;

  logic [5:0]  r_pal [16];
  logic [17:0] r_dac [256];

  logic [7:0]  r_s1_idx;
  logic        r_s1_blank;
  logic        r_s1_hs;
  logic        r_s1_vs;
  logic [3:0]  r_red_o;
  logic [3:0]  r_green_o;
  logic [3:0]  r_blue_o;
  logic        r_hs_o;
  logic        r_vs_o;

  logic [7:0]  w_dac_idx;
  logic [17:0] w_pix;

  // Host register state
  comp_e       r_cnt;
  comp_e       w_cnt_nxt;
  logic [7:0]  r_wr_idx;
  logic [7:0]  w_wr_idx_nxt;
  logic [7:0]  r_rd_idx;
  logic [7:0]  w_rd_idx_nxt;
  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [5:0]  r_red;
  logic [5:0]  w_red_nxt;
  logic [5:0]  r_green;
  logic [5:0]  w_green_nxt;
  logic [5:0]  r_dat_o;
  logic [5:0]  w_dat_o_nxt;
  logic        w_dac_we;
  logic [17:0] w_dac_wdata;
  logic [17:0] w_rd_entry;

  // Memories are deliberately not reset; reads of the written entry see old data.
  always_ff @(posedge clk) begin
    if (pal_we) r_pal[pal_addr] <= pal_write;
  end

  always_ff @(posedge clk) begin
    if (w_dac_we) r_dac[r_wr_idx] <= w_dac_wdata;
  end

  assign pal_read  = r_pal[pal_addr];
  assign w_dac_idx = (graphics_alpha & shift_reg1) ? character_pal_dac_i
                                                   : {2'b00, r_pal[character_pal_dac_i[3:0]]};
  assign w_pix     = r_dac[r_s1_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_idx   <= 8'd0;
      r_s1_blank <= 1'b0;
      r_s1_hs    <= 1'b0;
      r_s1_vs    <= 1'b0;
      r_red_o    <= 4'd0;
      r_green_o  <= 4'd0;
      r_blue_o   <= 4'd0;
      r_hs_o     <= 1'b0;
      r_vs_o     <= 1'b0;
    end else if (enable_pal_dac) begin
      r_s1_idx   <= w_dac_idx;
      r_s1_blank <= ~(video_on_h_pal_dac_i & video_on_v_pal_dac_i);
      r_s1_hs    <= horiz_sync_pal_dac_i;
      r_s1_vs    <= vert_sync_pal_dac_i;
      r_red_o    <= r_s1_blank ? 4'd0 : w_pix[17:14];
      r_green_o  <= r_s1_blank ? 4'd0 : w_pix[11:8];
      r_blue_o   <= r_s1_blank ? 4'd0 : w_pix[5:2];
      r_hs_o     <= r_s1_hs;
      r_vs_o     <= r_s1_vs;
    end
  end

  assign vga_red_o    = r_red_o;
  assign vga_green_o  = r_green_o;
  assign vga_blue_o   = r_blue_o;
  assign horiz_sync_o = r_hs_o;
  assign vert_sync_o  = r_vs_o;

  assign w_rd_entry = r_dac[r_rd_idx];

  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_wr_idx_nxt = r_wr_idx;
    w_rd_idx_nxt = r_rd_idx;
    w_state_nxt  = r_state;
    w_red_nxt    = r_red;
    w_green_nxt  = r_green;
    w_dat_o_nxt  = r_dat_o;
    w_dac_we     = 1'b0;
    w_dac_wdata  = {r_red, r_green, dac_dat_i};

    // Index loads restart the triplet and swallow any same-cycle data strobe.
    if (dac_wr_idx_we || dac_rd_idx_we) begin
      w_cnt_nxt = CompR;
      if (dac_wr_idx_we) begin
        w_wr_idx_nxt = dac_idx_i;
        w_state_nxt  = 2'b11;
      end
      if (dac_rd_idx_we) begin
        w_rd_idx_nxt = dac_idx_i;
        w_state_nxt  = 2'b00;
      end
    end else if (dac_dat_we) begin
      case (r_cnt)
        CompR: begin
          w_red_nxt = dac_dat_i;
          w_cnt_nxt = CompG;
        end
        CompG: begin
          w_green_nxt = dac_dat_i;
          w_cnt_nxt   = CompB;
        end
        default: begin
          w_dac_we     = 1'b1;
          w_wr_idx_nxt = r_wr_idx + 8'd1;
          w_cnt_nxt    = CompR;
        end
      endcase
    end else if (dac_dat_re) begin
      case (r_cnt)
        CompR: begin
          w_dat_o_nxt = w_rd_entry[17:12];
          w_cnt_nxt   = CompG;
        end
        CompG: begin
          w_dat_o_nxt = w_rd_entry[11:6];
          w_cnt_nxt   = CompB;
        end
        default: begin
          w_dat_o_nxt  = w_rd_entry[5:0];
          w_rd_idx_nxt = r_rd_idx + 8'd1;
          w_cnt_nxt    = CompR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= CompR;
      r_wr_idx <= 8'd0;
      r_rd_idx <= 8'd0;
      r_state  <= 2'b11;
      r_red    <= 6'd0;
      r_green  <= 6'd0;
      r_dat_o  <= 6'd0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_wr_idx <= w_wr_idx_nxt;
      r_rd_idx <= w_rd_idx_nxt;
      r_state  <= w_state_nxt;
      r_red    <= w_red_nxt;
      r_green  <= w_green_nxt;
      r_dat_o  <= w_dat_o_nxt;
    end
  end

  assign dac_dat_o   = r_dat_o;
  assign dac_state_o = r_state;

endmodule

// File: tb/tb_vga_palette_dac.sv
// Scoreboard bench for vga_palette_dac: stimulus pushes expected pixels and
// expected host read data; monitor processes pop and compare.
module tb_vga_palette_dac;

  logic       clk;
  logic       rst;
  logic       enable_pal_dac;
  logic       horiz_sync_pal_dac_i;
  logic       vert_sync_pal_dac_i;
  logic       video_on_h_pal_dac_i;
  logic       video_on_v_pal_dac_i;
  logic [7:0] character_pal_dac_i;
  logic       graphics_alpha;
  logic       shift_reg1;
  logic [3:0] pal_addr;
  logic       pal_we;
  logic [5:0] pal_write;
  logic [5:0] pal_read;
  logic       dac_wr_idx_we;
  logic       dac_rd_idx_we;
  logic [7:0] dac_idx_i;
  logic       dac_dat_we;
  logic       dac_dat_re;
  logic [5:0] dac_dat_i;
  logic [5:0] dac_dat_o;
  logic [1:0] dac_state_o;
  logic [3:0] vga_red_o;
  logic [3:0] vga_green_o;
  logic [3:0] vga_blue_o;
  logic       horiz_sync_o;
  logic       vert_sync_o;

  vga_palette_dac dut (
    .clk                  (clk),
    .rst                  (rst),
    .enable_pal_dac       (enable_pal_dac),
    .horiz_sync_pal_dac_i (horiz_sync_pal_dac_i),
    .vert_sync_pal_dac_i  (vert_sync_pal_dac_i),
    .video_on_h_pal_dac_i (video_on_h_pal_dac_i),
    .video_on_v_pal_dac_i (video_on_v_pal_dac_i),
    .character_pal_dac_i  (character_pal_dac_i),
    .graphics_alpha       (graphics_alpha),
    .shift_reg1           (shift_reg1),
    .pal_addr             (pal_addr),
    .pal_we               (pal_we),
    .pal_write            (pal_write),
    .pal_read             (pal_read),
    .dac_wr_idx_we        (dac_wr_idx_we),
    .dac_rd_idx_we        (dac_rd_idx_we),
    .dac_idx_i            (dac_idx_i),
    .dac_dat_we           (dac_dat_we),
    .dac_dat_re           (dac_dat_re),
    .dac_dat_i            (dac_dat_i),
    .dac_dat_o            (dac_dat_o),
    .dac_state_o          (dac_state_o),
    .vga_red_o            (vga_red_o),
    .vga_green_o          (vga_green_o),
    .vga_blue_o           (vga_blue_o),
    .horiz_sync_o         (horiz_sync_o),
    .vert_sync_o          (vert_sync_o)
  );

  typedef struct packed {
    logic        chk;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } pix_t;

  pix_t       pix_q[$];
  logic [5:0] rd_q[$];
  int         total;
  int         bad;
  bit         pix_on;

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel monitor: output after the n-th enabled edge belongs to pixel n-1.
  initial begin
    pix_t e;
    pix_t last;
    int   n;
    bit   en_s;
    n    = 0;
    last = '0;
    forever begin
      @(posedge clk);
      en_s = enable_pal_dac && pix_on;
      #1;
      if (!pix_on) begin
        n = 0;
      end else if (en_s) begin
        n++;
        if (n >= 2) begin
          if (pix_q.size() == 0) begin
            chk("pix_q_underflow", 32'd1, 32'd0);
          end else begin
            e    = pix_q.pop_front();
            last = e;
            if (e.chk) begin
              chk("pix_rgb", 32'({vga_red_o, vga_green_o, vga_blue_o}), 32'(e.rgb));
              chk("pix_sync", 32'({horiz_sync_o, vert_sync_o}), 32'({e.hs, e.vs}));
            end
          end
        end
      end else if (n >= 2 && last.chk) begin
        chk("pix_hold_rgb", 32'({vga_red_o, vga_green_o, vga_blue_o}), 32'(last.rgb));
      end
    end
  end

  // Host read monitor: an effective read strobe yields data one cycle later.
  initial begin
    bit re_s;
    forever begin
      @(posedge clk);
      re_s = dac_dat_re & ~dac_dat_we & ~dac_wr_idx_we & ~dac_rd_idx_we;
      #1;
      if (re_s) begin
        if (rd_q.size() == 0) chk("rd_q_underflow", 32'd1, 32'd0);
        else chk("dac_rd", 32'(dac_dat_o), 32'(rd_q.pop_front()));
      end
    end
  end

  task automatic wr_idx(input logic [7:0] i);
    dac_wr_idx_we = 1'b1;
    dac_idx_i     = i;
    @(negedge clk);
    dac_wr_idx_we = 1'b0;
  endtask

  task automatic rd_idx(input logic [7:0] i);
    dac_rd_idx_we = 1'b1;
    dac_idx_i     = i;
    @(negedge clk);
    dac_rd_idx_we = 1'b0;
  endtask

  task automatic wr_dat(input logic [5:0] d);
    dac_dat_we = 1'b1;
    dac_dat_i  = d;
    @(negedge clk);
    dac_dat_we = 1'b0;
  endtask

  task automatic rd_dat(input logic [5:0] exp);
    rd_q.push_back(exp);
    dac_dat_re = 1'b1;
    @(negedge clk);
    dac_dat_re = 1'b0;
  endtask

  task automatic pal_wr(input logic [3:0] a, input logic [5:0] d);
    pal_we    = 1'b1;
    pal_addr  = a;
    pal_write = d;
    @(negedge clk);
    pal_we    = 1'b0;
  endtask

  task automatic pix(input logic [7:0] ch, input logic ga, input logic sr, input logic hon,
                     input logic von, input logic hs, input logic vs, input logic [11:0] rgb,
                     input logic c);
    pix_t e;
    character_pal_dac_i  = ch;
    graphics_alpha       = ga;
    shift_reg1           = sr;
    video_on_h_pal_dac_i = hon;
    video_on_v_pal_dac_i = von;
    horiz_sync_pal_dac_i = hs;
    vert_sync_pal_dac_i  = vs;
    e.chk = c;
    e.hs  = hs;
    e.vs  = vs;
    e.rgb = rgb;
    pix_q.push_back(e);
    pix_on = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    pix_on = 1'b0;
    rst = 1'b1;
    enable_pal_dac = 1'b1;
    horiz_sync_pal_dac_i = 1'b1;
    vert_sync_pal_dac_i  = 1'b1;
    video_on_h_pal_dac_i = 1'b1;
    video_on_v_pal_dac_i = 1'b1;
    character_pal_dac_i  = 8'h00;
    graphics_alpha = 1'b1;
    shift_reg1     = 1'b1;
    pal_addr = 4'd0;
    pal_we = 1'b0;
    pal_write = 6'd0;
    dac_wr_idx_we = 1'b0;
    dac_rd_idx_we = 1'b0;
    dac_idx_i = 8'd0;
    dac_dat_we = 1'b0;
    dac_dat_re = 1'b0;
    dac_dat_i = 6'd0;

    repeat (2) @(negedge clk);
    chk("rst_rgb", 32'({vga_red_o, vga_green_o, vga_blue_o}), 32'h0);
    chk("rst_sync", 32'({horiz_sync_o, vert_sync_o}), 32'h0);
    chk("rst_dat_o", 32'(dac_dat_o), 32'h0);
    chk("rst_state", 32'(dac_state_o), 32'h3);
    rst = 1'b0;
    @(negedge clk);

    // Triplet write at 05, then wr_index must have moved to 06.
    wr_idx(8'h05);
    wr_dat(6'h3F); wr_dat(6'h00); wr_dat(6'h15);
    chk("state_wr", 32'(dac_state_o), 32'h3);
    wr_dat(6'h0A); wr_dat(6'h0B); wr_dat(6'h0C);
    rd_idx(8'h06);
    chk("state_rd", 32'(dac_state_o), 32'h0);
    rd_dat(6'h0A); rd_dat(6'h0B); rd_dat(6'h0C);
    rd_idx(8'h05);
    rd_dat(6'h3F); rd_dat(6'h00); rd_dat(6'h15);
    chk("dat_o_hold", 32'(dac_dat_o), 32'h15);

    // Write index wraps 255 -> 0; read index wraps likewise.
    wr_idx(8'hFF);
    wr_dat(6'h01); wr_dat(6'h02); wr_dat(6'h03);
    wr_dat(6'h04); wr_dat(6'h05); wr_dat(6'h06);
    rd_idx(8'hFF);
    rd_dat(6'h01); rd_dat(6'h02); rd_dat(6'h03);
    rd_dat(6'h04); rd_dat(6'h05); rd_dat(6'h06);
    chk("state_rd_wrap", 32'(dac_state_o), 32'h0);

    wr_idx(8'h40);
    wr_dat(6'h10); wr_dat(6'h20); wr_dat(6'h30);
    wr_idx(8'h2A);
    wr_dat(6'h3F); wr_dat(6'h3F); wr_dat(6'h3F);
    pal_wr(4'd3, 6'h2A);
    pal_wr(4'd7, 6'h05);
    pal_addr = 4'd3;
    #1 chk("pal_read3", 32'(pal_read), 32'h2A);
    pal_addr = 4'd7;
    #1 chk("pal_read7", 32'(pal_read), 32'h05);
    @(negedge clk);

    // Pixel path
    pix(8'h05, 1, 1, 1, 1, 1, 0, 12'hF05, 1);
    pix(8'h83, 0, 0, 1, 1, 0, 1, 12'hFFF, 1);
    pix(8'h40, 1, 1, 1, 0, 0, 0, 12'h000, 1);
    pix(8'h40, 1, 1, 1, 1, 0, 0, 12'h48C, 1);
    pix(8'h13, 1, 0, 1, 1, 1, 0, 12'hFFF, 1);
    enable_pal_dac = 1'b0;
    character_pal_dac_i  = 8'hFF;
    video_on_v_pal_dac_i = 1'b0;
    horiz_sync_pal_dac_i = 1'b0;
    repeat (3) @(negedge clk);
    enable_pal_dac = 1'b1;
    pix(8'hF7, 0, 0, 1, 1, 0, 1, 12'hF05, 1);
    pix(8'h05, 1, 1, 1, 1, 1, 1, 12'hF05, 1);
    pix(8'h05, 1, 1, 1, 1, 1, 1, 12'hF05, 0);
    pix(8'h05, 1, 1, 1, 1, 1, 1, 12'hF05, 0);
    pix_on = 1'b0;
    pix_q.delete();

    // Partial triplet then async reset: RAM untouched, counter back to R.
    wr_idx(8'h10);
    wr_dat(6'h11); wr_dat(6'h12); wr_dat(6'h13);
    rd_idx(8'h10);
    rd_dat(6'h11); rd_dat(6'h12); rd_dat(6'h13);
    wr_idx(8'h10);
    wr_dat(6'h21); wr_dat(6'h22);
    #5 rst = 1'b1;
    #1;
    chk("arst_rgb", 32'({vga_red_o, vga_green_o, vga_blue_o}), 32'h0);
    chk("arst_sync", 32'({horiz_sync_o, vert_sync_o}), 32'h0);
    chk("arst_dat_o", 32'(dac_dat_o), 32'h0);
    chk("arst_state", 32'(dac_state_o), 32'h3);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wr_dat(6'h31); wr_dat(6'h32); wr_dat(6'h33);
    rd_idx(8'h10);
    rd_dat(6'h11); rd_dat(6'h12); rd_dat(6'h13);
    rd_idx(8'h00);
    rd_dat(6'h31); rd_dat(6'h32); rd_dat(6'h33);

    // Index load beats data strobes; data write beats data read.
    dac_wr_idx_we = 1'b1; dac_idx_i = 8'h20; dac_dat_we = 1'b1; dac_dat_i = 6'h3F;
    @(negedge clk);
    dac_wr_idx_we = 1'b0; dac_dat_we = 1'b0;
    wr_dat(6'h01); wr_dat(6'h02); wr_dat(6'h03);
    dac_rd_idx_we = 1'b1; dac_idx_i = 8'h20; dac_dat_re = 1'b1;
    @(negedge clk);
    dac_rd_idx_we = 1'b0; dac_dat_re = 1'b0;
    rd_dat(6'h01); rd_dat(6'h02); rd_dat(6'h03);
    wr_idx(8'h21);
    dac_dat_we = 1'b1; dac_dat_re = 1'b1; dac_dat_i = 6'h07;
    @(negedge clk);
    dac_dat_we = 1'b0; dac_dat_re = 1'b0;
    wr_dat(6'h08); wr_dat(6'h09);
    rd_idx(8'h21);
    rd_dat(6'h07); rd_dat(6'h08); rd_dat(6'h09);

    repeat (4) @(negedge clk);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_palette_dac.md
Name: vga_palette_dac

Overview:
- Stage directly downstream of the VGA sequencer. Consumes its character/attribute byte, syncs and video_on flags.
- Maps the byte through the 16-entry attribute palette (text and planar modes) and the 256-entry, 18-bit DAC RAM.
- Drives 4-bit RGB and the matching delayed syncs to the pins.
- Also provides the host-side DAC register interface: write index, read index, and the data port with the R/G/B triplet state machine.

Parameters:
- none

Ports:
- clk  input  1  pixel clock (25 MHz)
- rst  input  1  asynchronous active-high reset
- enable_pal_dac  input  1  pixel-path advance strobe; low means the pipeline holds
- horiz_sync_pal_dac_i  input  1  horizontal sync from sequencer
- vert_sync_pal_dac_i  input  1  vertical sync from sequencer
- video_on_h_pal_dac_i  input  1  horizontal display enable
- video_on_v_pal_dac_i  input  1  vertical display enable
- character_pal_dac_i  input  8  sequencer pixel byte
- graphics_alpha  input  1  graphics mode select
- shift_reg1  input  1  256-colour mode select
- pal_addr  input  4  attribute palette host address
- pal_we  input  1  attribute palette write strobe
- pal_write  input  6  attribute palette write data
- pal_read  output  6  attribute palette read data (combinational, at pal_addr)
- dac_wr_idx_we  input  1  load write index (3C8)
- dac_rd_idx_we  input  1  load read index (3C7)
- dac_idx_i  input  8  index data for either load strobe
- dac_dat_we  input  1  data write strobe (3C9)
- dac_dat_re  input  1  data read strobe (3C9)
- dac_dat_i  input  6  colour component write data
- dac_dat_o  output  6  colour component read data
- dac_state_o  output  2  2'b11 = write mode, 2'b00 = read mode
- vga_red_o  output  4  red
- vga_green_o  output  4  green
- vga_blue_o  output  4  blue
- horiz_sync_o  output  1  delayed horizontal sync
- vert_sync_o  output  1  delayed vertical sync

Behaviour:
- Reset (async):
  - RGB, syncs and dac_dat_o = 0; pipeline registers = 0.
  - wr_index = 0, rd_index = 0, component counter = R, dac_state_o = 2'b11.
  - Palette and DAC RAM contents are not cleared.
- Pixel path: 2-stage pipeline, advances only on cycles where enable_pal_dac = 1; otherwise every stage holds.
  - Stage 1, index select:
    - dac_idx = character_pal_dac_i when graphics_alpha & shift_reg1.
    - Otherwise dac_idx = {2'b00, palette[character_pal_dac_i[3:0]]}.
    - Stage 1 registers dac_idx, blank = ~(video_on_h & video_on_v), and both syncs.
  - Stage 2, DAC lookup:
    - RGB = blank ? 0 : {dac[idx].r[5:2], dac[idx].g[5:2], dac[idx].b[5:2]}.
    - Syncs are copied from stage 1.
  - Latency: output appears on the second enabled edge after the input; syncs and RGB stay aligned.
- Attribute palette: 16x6 RAM.
  - Write is synchronous on pal_we.
  - The pixel-side read is combinational at stage 1.
  - Same-cycle write and pixel read of the same entry returns the old value.
- DAC RAM: 256x18 ({r,g,b}, 6 bits each). The host write port and the pixel read port are independent. Same-address collision: the pixel side sees the old value.
- dac_wr_idx_we: wr_index <= dac_idx_i; counter <= R; dac_state_o <= 2'b11.
- dac_rd_idx_we: rd_index <= dac_idx_i; counter <= R; dac_state_o <= 2'b00.
- dac_dat_we, triplet write:
  - R: latch red, counter to G.
  - G: latch green, counter to B.
  - B: write {red, green, dac_dat_i} to dac[wr_index]; wr_index <= wr_index + 1 (8-bit wrap, 255 -> 0); counter to R.
- dac_dat_re, triplet read:
  - dac_dat_o <= component(counter) of dac[rd_index], valid one cycle after the strobe; counter advances R -> G -> B.
  - On B, rd_index <= rd_index + 1 (wraps).
  - dac_dat_o holds between reads.
- One counter is shared by reads and writes; it is not mode-checked.
- Priority in the same cycle: index load beats data strobe, and the data strobe is dropped. dac_dat_we beats dac_dat_re.
- Partial triplets are discarded on any index load or reset; the RAM is untouched.
- Host port ignores enable_pal_dac.

Test Plan:
- Write idx 8'h05, then data 3F, 00, 15 -> dac[5] = {3F,00,15}, wr_index = 6. Mode 13h pixel 8'h05 with video on -> RGB = F,0,5 two enabled cycles later; syncs delayed identically.
- Write idx 8'hFF, then two triplets -> second lands in dac[0]. Read idx 8'hFF + 6 reads -> dac_dat_o returns both triplets in R,G,B order; dac_state_o = 00.
- Text mode, palette[3] = 6'h2A, dac[8'h2A] = {3F,3F,3F}, char 8'h83 -> RGB = F,F,F.
- video_on_v low for one pixel -> RGB = 0 for exactly that pixel, two enabled cycles later.
- enable_pal_dac low for 3 cycles mid-line -> outputs frozen; sequence resumes with no lost or duplicated pixel.
- Write idx 8'h10, two data writes, then async rst -> dac[0x10] unchanged, counter = R, dac_state_o = 11. Index load with simultaneous dac_dat_we -> data dropped.
